// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
  } instr_fields_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer of {pc, instr} pairs with a registered head
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_instr,
  input  logic                     pop,
  output logic                     valid,
  output logic [31:0]              head_pc,
  output logic [31:0]              head_instr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign valid      = (count != '0);
  assign head_pc    = mem_pc[rd_ptr];
  assign head_instr = mem_instr[rd_ptr];
  assign do_pop     = pop & valid;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push    = push & ((count != FULL) | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem_pc[wr_ptr]    <= push_pc;
        mem_instr[wr_ptr] <= push_instr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, credit-limited imem issue, redirect/flush and decoded head instruction
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_flush_cnt outputs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rd
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  fetch_state_t  state, state_nxt;
  instr_fields_t fields;
  logic [31:0]   fetch_pc, resp_pc, target;
  logic [CW-1:0] outstanding, out_nxt, drop_cnt, drop_nxt, fifo_count;
  logic          accept, push, pop;

  assign accept    = imem_req & imem_ready;
  // Words from before a redirect are discarded, including one landing on the redirect cycle.
  assign push      = imem_rvalid & (drop_cnt == '0) & ~branch_taken;
  assign pop       = instr_valid & instr_ready;
  assign target    = branch_target & ~32'h3;
  assign imem_addr = fetch_pc;

  always_comb begin
    out_nxt = outstanding;
    if (accept && !imem_rvalid) begin
      out_nxt = outstanding + 1'b1;
    end else if (!accept && imem_rvalid) begin
      out_nxt = outstanding - 1'b1;
    end
  end

  always_comb begin
    drop_nxt = drop_cnt;
    if (branch_taken) begin
      drop_nxt = out_nxt;
    end else if (imem_rvalid && drop_cnt != '0) begin
      drop_nxt = drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:           state_nxt = S_FETCH;
      S_FETCH, S_FLUSH: state_nxt = (drop_nxt != '0) ? S_FLUSH : S_FETCH;
      default:          state_nxt = S_BOOT;
    endcase
  end

  // Buffered plus in-flight words never exceed the buffer size, so pushes cannot overflow.
  always_comb begin
    imem_req = 1'b0;
    if (state == S_FETCH) begin
      imem_req = ({1'b0, fifo_count} + {1'b0, outstanding}) < CREDITS;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      drop_cnt    <= drop_nxt;
      if (branch_taken) begin
        fetch_pc <= target;
        resp_pc  <= target;
      end else begin
        if (accept) fetch_pc <= fetch_pc + WORD_BYTES;
        if (push)   resp_pc  <= resp_pc + WORD_BYTES;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (branch_taken),
    .push       (push),
    .push_pc    (resp_pc),
    .push_instr (imem_rdata),
    .pop        (pop),
    .valid      (instr_valid),
    .head_pc    (instr_pc),
    .head_instr (instr),
    .count      (fifo_count)
  );

  assign fields = '{cond: instr[31:28], op: instr[27:26], funct: instr[25:20], rd: instr[15:12]};
  assign cond   = fields.cond;
  assign op     = fields.op;
  assign funct  = fields.funct;
  assign rd     = fields.rd;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push)         perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (branch_taken) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with an in-order memory model
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          DEPTH    = 2;

  logic        clk, rst;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [3:0]  cond, rd;
  logic [1:0]  op;
  logic [5:0]  funct;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .cond          (cond),
    .op            (op),
    .funct         (funct),
    .rd            (rd)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  int          tick = 0;
  int          errors = 0, checks = 0;
  int          n_acc, n_pop, n_good, n_br;
  int          first_acc_t, first_val_t;
  logic [31:0] first_acc_addr;
  logic [31:0] exp_pc;
  bit          rdy_rand, pop_rand, pop_en, br_now;
  logic [31:0] br_tgt;
  int          lat_min, lat_max;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[9:2], ~a[9:2], a[17:2]} ^ 32'h5A3C_0F81;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Entered and left at a falling edge: check the head, then drive inputs for the next rising edge.
  task automatic cycle();
    logic [31:0] e;
    bit          rsp_stale;
    imem_ready  = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    instr_ready = pop_rand ? ($urandom_range(0, 1) == 1) : pop_en;
    if (instr_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'b0, instr_valid}, 32'd0);
      end else begin
        e = exp_q[0].word;
        check("head_pc", instr_pc, exp_q[0].pc);
        check("head_instr", instr, e);
        check("head_fields", {16'b0, cond, op, funct, rd},
              {16'b0, e[31:28], e[27:26], e[25:20], e[15:12]});
        if (first_val_t < 0) first_val_t = tick + 1;
        if (instr_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
    rsp_stale = 1'b0;
    if (pend.size() != 0 && pend[0].due <= tick + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(pend[0].addr);
      rsp_stale   = pend[0].stale;
      void'(pend.pop_front());
      if (!rsp_stale && !br_now) n_good++;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if (imem_req && imem_ready) begin
      check("acc_addr", imem_addr, exp_pc);
      if (first_acc_t < 0) begin
        first_acc_t    = tick + 1;
        first_acc_addr = imem_addr;
      end
      pend.push_back('{addr: imem_addr, due: tick + 1 + $urandom_range(lat_max, lat_min), stale: 1'b0});
      exp_q.push_back('{pc: exp_pc, word: word_of(exp_pc)});
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    branch_taken  = br_now;
    branch_target = br_tgt;
    if (br_now) begin
      exp_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_pc = br_tgt & ~32'h3;
      n_br++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; branch_taken = 1'b0; instr_ready = 1'b0;
    pend.delete(); exp_q.delete();
    exp_pc = RESET_PC;
    n_acc = 0; n_pop = 0; n_good = 0; n_br = 0;
    first_acc_t = -1; first_val_t = -1; first_acc_addr = 32'hDEAD_BEEF;
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n = 0;
    while (!instr_valid && n < limit) begin
      cycle();
      n++;
    end
    check(tag, {31'b0, instr_valid}, 32'd1);
  endtask

  function automatic bit resp_due_now();
    return pend.size() != 0 && pend[0].due <= tick + 1;
  endfunction

  initial begin
    int n;
    rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    branch_taken = 1'b0; branch_target = '0; instr_ready = 1'b0;
    rdy_rand = 1'b0; pop_rand = 1'b0; pop_en = 1'b1; br_now = 1'b0; br_tgt = '0;
    lat_min = 1; lat_max = 1;
    @(negedge clk);

    do_reset();
    repeat (12) cycle();
    check("first_latency", first_val_t - first_acc_t, 32'd2);
    check("first_acc_addr", first_acc_addr, RESET_PC);

    do_reset();
    pop_en = 1'b0;
    repeat (12) cycle();
    check("bp_accepts", n_acc, DEPTH);
    check("bp_req_low", {31'b0, imem_req}, 32'd0);
    pop_en = 1'b1; cycle(); pop_en = 1'b0;
    repeat (8) cycle();
    check("bp_resume", n_acc, DEPTH + 1);
    pop_en = 1'b1;

    do_reset();
    lat_min = 3; lat_max = 3;
    n = 0;
    while (pend.size() < 2 && n < 20) begin cycle(); n++; end
    check("two_in_flight", pend.size(), 32'd2);
    br_now = 1'b1; br_tgt = 32'h100; cycle(); br_now = 1'b0;
    wait_valid("redirect_valid", 20);
    check("redirect_pc", instr_pc, 32'h100);
    repeat (6) cycle();
    lat_min = 1; lat_max = 1;

    do_reset();
    n = 0;
    while (!(instr_valid && resp_due_now()) && n < 20) begin cycle(); n++; end
    check("same_cycle_setup", {31'b0, instr_valid && resp_due_now()}, 32'd1);
    br_now = 1'b1; br_tgt = 32'h200; cycle(); br_now = 1'b0;
    check("same_cycle_empty", {31'b0, instr_valid}, 32'd0);
    wait_valid("same_cycle_valid", 20);
    check("same_cycle_pc", instr_pc, 32'h200);

    repeat (3) cycle();
    br_now = 1'b1; br_tgt = 32'hFFFF_FFFB; cycle(); br_now = 1'b0;
    wait_valid("wrap_valid", 20);
    check("wrap_pc", instr_pc, 32'hFFFF_FFF8);
    repeat (8) cycle();

    do_reset();
    repeat (6) cycle();
    check("restart_addr", first_acc_addr, RESET_PC);

    do_reset();
    rdy_rand = 1'b1; pop_rand = 1'b1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      br_now = ($urandom_range(0, 24) == 0);
      br_tgt = $urandom;
      cycle();
    end
    br_now = 1'b0; rdy_rand = 1'b0; pop_rand = 1'b0; pop_en = 1'b1;
    repeat (20) cycle();
    check("random_progress", {31'b0, n_pop > 20}, 32'd1);

`ifdef FETCH_PERF_EN
    do_reset();
    lat_min = 1; lat_max = 1;
    n = 0;
    while (!(n_good >= 10 && n > 12) && n < 200) begin
      br_now = (n == 6 || n == 12);
      br_tgt = 32'h400 + 32'(n) * 32'h40;
      cycle();
      n++;
    end
    br_now = 1'b0;
    check("perf_fetch", perf_fetch_cnt, n_good);
    check("perf_flush", perf_flush_cnt, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
